// File: rtl/ham_encoder_tx.sv
// -----------------------------------------------------------------------------
// ham_encoder_tx
//
// Hamming(7,4) transmit encoder. Accepts a data nibble over a valid/ready
// handshake, encodes it into a 7-bit codeword with the layout the decoder
// expects, and serializes the codeword one bit at a time:
//   - tx_frame marks the cycles where tx_bit carries a codeword bit,
//   - every bit is held for BIT_CYCLES clocks,
//   - GAP_CYCLES idle clocks follow each frame before in_ready returns,
//   - done pulses for one cycle as the frame finishes.
//
// Codeword layout, par_code = {e6,e5,e4,e3,e2,e1,e0}:
//   e6=d3  e5=d2  e4=d1  e2=d0
//   e3=d3^d2^d1  e1=d3^d2^d0  e0=d3^d1^d0
// The layout gives a decoder syndrome of zero for a clean codeword and
// index+1 for a single flipped bit at that index.
//
// Optional build macro HAM_ERR_INJ_EN: adds err_inj_en / err_inj_pos. When
// err_inj_en=1 and err_inj_pos!=0 at accept, codeword bit err_inj_pos-1 is
// inverted before capture. Without the macro the codeword is always clean.
// -----------------------------------------------------------------------------
module ham_encoder_tx #(
    parameter int unsigned BIT_CYCLES = 4,  // clocks per serial bit, >= 1
    parameter int unsigned GAP_CYCLES = 1,  // idle clocks after a frame, >= 0
    parameter int unsigned LSB_FIRST  = 1   // 1: code[0] first, 0: code[6] first
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
`ifdef HAM_ERR_INJ_EN
    input  logic       err_inj_en,
    input  logic [2:0] err_inj_pos,
`endif
    output logic [6:0] par_code,
    output logic       tx_bit,
    output logic       tx_frame,
    output logic       busy,
    output logic       done
);

    // -------------------------------------------------------------------------
    // Counter sizing
    // -------------------------------------------------------------------------
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [2:0]       BIT_LAST = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Codeword construction
    // -------------------------------------------------------------------------
    function automatic logic [6:0] ham_encode(input logic [3:0] d);
        logic p3;
        logic p1;
        logic p0;
        p3 = d[3] ^ d[2] ^ d[1];
        p1 = d[3] ^ d[2] ^ d[0];
        p0 = d[3] ^ d[1] ^ d[0];
        return {d[3], d[2], d[1], p3, d[0], p1, p0};
    endfunction

    // Codeword presented for capture on the accept edge.
    logic [6:0] accept_code;

`ifdef HAM_ERR_INJ_EN
    // Encode the incoming nibble and optionally invert one selected bit.
    always_comb begin
        accept_code = ham_encode(in_data);
        if (err_inj_en && (err_inj_pos != 3'd0)) begin
            accept_code = accept_code ^ (7'b000_0001 << (err_inj_pos - 3'd1));
        end
    end
`else
    assign accept_code = ham_encode(in_data);
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [6:0]       sh_q,       sh_d;        // remaining bits, current bit at the exit end
    logic [6:0]       code_q,     code_d;      // par_code register
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [CYC_W-1:0] cyc_cnt_q,  cyc_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic             tx_bit_q,   tx_bit_d;
    logic             tx_frame_q, tx_frame_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic accept;

    // Ready only when idle and not being reset, so reset always wins over accept.
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        sh_d       = sh_q;
        code_d     = code_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_bit_d   = 1'b0;
        tx_frame_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SHIFT;
                    sh_d       = accept_code;
                    code_d     = accept_code;
                    bit_cnt_d  = 3'd0;
                    cyc_cnt_d  = '0;
                    tx_bit_d   = (LSB_FIRST != 0) ? accept_code[0] : accept_code[6];
                    tx_frame_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end

            ST_SHIFT: begin
                tx_frame_d = 1'b1;
                busy_d     = 1'b1;
                tx_bit_d   = tx_bit_q;
                if (cyc_cnt_q == CYC_LAST) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        // Last bit has been held long enough: close the frame.
                        tx_frame_d = 1'b0;
                        tx_bit_d   = 1'b0;
                        done_d     = 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        // Advance to the next codeword bit.
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (LSB_FIRST != 0) begin
                            sh_d     = {1'b0, sh_q[6:1]};
                            tx_bit_d = sh_q[1];
                        end else begin
                            sh_d     = {sh_q[5:0], 1'b0};
                            tx_bit_d = sh_q[5];
                        end
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            code_q     <= '0;
            bit_cnt_q  <= '0;
            cyc_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tx_bit_q   <= 1'b0;
            tx_frame_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            code_q     <= code_d;
            bit_cnt_q  <= bit_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign par_code = code_q;
    assign tx_bit   = tx_bit_q;
    assign tx_frame = tx_frame_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ham_encoder_tx.sv
// -----------------------------------------------------------------------------
// tb_ham_encoder_tx
//
// Two encoder instances share one clock:
//   a: BIT_CYCLES=4, GAP_CYCLES=1, LSB_FIRST=1 (defaults)
//   b: BIT_CYCLES=1, GAP_CYCLES=0, LSB_FIRST=0
// The reference codeword is built from the decoder property (syndrome = XOR of
// index+1 over set bits must be zero); frame timing is predicted from cycle
// arithmetic relative to the accept edge.
// -----------------------------------------------------------------------------
module tb_ham_encoder_tx;

    localparam int A_BC  = 4;
    localparam int A_GAP = 1;
    localparam int A_LSB = 1;
    localparam int B_BC  = 1;
    localparam int B_GAP = 0;
    localparam int B_LSB = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_in_valid, a_in_ready, a_tx_bit, a_tx_frame, a_busy, a_done;
    logic [3:0] a_in_data;
    logic [6:0] a_par_code;
    logic       b_rst, b_in_valid, b_in_ready, b_tx_bit, b_tx_frame, b_busy, b_done;
    logic [3:0] b_in_data;
    logic [6:0] b_par_code;
`ifdef HAM_ERR_INJ_EN
    logic       a_err_en, b_err_en;
    logic [2:0] a_err_pos, b_err_pos;
    logic       cur_err_en;
    logic [2:0] cur_err_pos;
`endif

    int total = 0;
    int bad   = 0;

    logic [6:0] pc_obs;   // par_code seen in the first frame cycle
    logic [6:0] seq_obs;  // serial bits, first transmitted in bit 6

    ham_encoder_tx #(.BIT_CYCLES(A_BC), .GAP_CYCLES(A_GAP), .LSB_FIRST(A_LSB)) dut_a (
        .clk        (clk),
        .rst        (a_rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
`ifdef HAM_ERR_INJ_EN
        .err_inj_en (a_err_en),
        .err_inj_pos(a_err_pos),
`endif
        .par_code   (a_par_code),
        .tx_bit     (a_tx_bit),
        .tx_frame   (a_tx_frame),
        .busy       (a_busy),
        .done       (a_done)
    );

    ham_encoder_tx #(.BIT_CYCLES(B_BC), .GAP_CYCLES(B_GAP), .LSB_FIRST(B_LSB)) dut_b (
        .clk        (clk),
        .rst        (b_rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
`ifdef HAM_ERR_INJ_EN
        .err_inj_en (b_err_en),
        .err_inj_pos(b_err_pos),
`endif
        .par_code   (b_par_code),
        .tx_bit     (b_tx_bit),
        .tx_frame   (b_tx_frame),
        .busy       (b_busy),
        .done       (b_done)
    );

    // ------------------------------------------------------------------ model
    function automatic logic [2:0] syndrome(input logic [6:0] c);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (c[3'(i)]) s = s ^ 3'(i + 1);
        end
        return s;
    endfunction

    // Data at positions 2,4,5,6; parity positions 0,1,3 (weights 1,2,4) are
    // chosen so the overall syndrome is zero.
    function automatic logic [6:0] model_encode(input logic [3:0] d);
        logic [6:0] c;
        logic [2:0] s;
        c    = 7'd0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        s    = syndrome(c);
        c[0] = s[0];
        c[1] = s[1];
        c[3] = s[2];
        return c;
    endfunction

    // --------------------------------------------------------------- drivers
    task automatic drive_in(input int sel, input logic v, input logic [3:0] d);
        if (sel == 0) begin
            a_in_valid = v;
            a_in_data  = d;
        end else begin
            b_in_valid = v;
            b_in_data  = d;
        end
    endtask

`ifdef HAM_ERR_INJ_EN
    task automatic set_err(input int sel, input logic e, input logic [2:0] p);
        if (sel == 0) begin
            a_err_en  = e;
            a_err_pos = p;
        end else begin
            b_err_en  = e;
            b_err_pos = p;
        end
    endtask
`endif

    // Wait for in_ready, accept nibble d, then check every cycle of the frame
    // up to and including the cycle where in_ready returns. Must be entered
    // between a falling edge and the next rising edge.
    task automatic run_frame(input int sel, input logic [3:0] d, input bit keep_valid);
        int         bc, gap, lsb, period, waited, k;
        logic [6:0] code;
        logic       o_ready, o_frame, o_bit, o_done, o_busy;
        logic [6:0] o_pc;
        logic       exp_frame, exp_bit, exp_done, exp_busy, exp_ready;
        bc     = (sel == 0) ? A_BC  : B_BC;
        gap    = (sel == 0) ? A_GAP : B_GAP;
        lsb    = (sel == 0) ? A_LSB : B_LSB;
        period = 7 * bc + gap + 1;
        code   = model_encode(d);
`ifdef HAM_ERR_INJ_EN
        if (cur_err_en && (cur_err_pos != 3'd0))
            code[cur_err_pos - 3'd1] = ~code[cur_err_pos - 3'd1];
`endif
        waited  = 0;
        o_ready = (sel == 0) ? a_in_ready : b_in_ready;
        while ((o_ready !== 1'b1) && (waited < 200)) begin
            @(negedge clk);
            waited++;
            o_ready = (sel == 0) ? a_in_ready : b_in_ready;
        end
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait sel=%0d in_ready=%b after %0d cycles, need 1", sel, o_ready, waited);
        end
        drive_in(sel, 1'b1, d);
`ifdef HAM_ERR_INJ_EN
        set_err(sel, cur_err_en, cur_err_pos);
`endif
        seq_obs = 7'd0;
        for (int n = 1; n <= period; n++) begin
            @(negedge clk);
            o_ready = (sel == 0) ? a_in_ready : b_in_ready;
            o_frame = (sel == 0) ? a_tx_frame : b_tx_frame;
            o_bit   = (sel == 0) ? a_tx_bit   : b_tx_bit;
            o_done  = (sel == 0) ? a_done     : b_done;
            o_busy  = (sel == 0) ? a_busy     : b_busy;
            o_pc    = (sel == 0) ? a_par_code : b_par_code;

            k         = (n - 1) / bc;
            exp_frame = (n <= 7 * bc);
            exp_bit   = 1'b0;
            if (exp_frame) exp_bit = (lsb != 0) ? code[3'(k)] : code[3'(6 - k)];
            exp_done  = (n == 7 * bc + 1);
            exp_busy  = (n <= 7 * bc + gap);
            exp_ready = (n == period);

            total++;
            if (o_frame !== exp_frame) begin
                bad++;
                $display("FAIL tx_frame sel=%0d n=%0d got=%b want=%b", sel, n, o_frame, exp_frame);
            end
            total++;
            if (o_bit !== exp_bit) begin
                bad++;
                $display("FAIL tx_bit sel=%0d n=%0d got=%b want=%b", sel, n, o_bit, exp_bit);
            end
            total++;
            if (o_done !== exp_done) begin
                bad++;
                $display("FAIL done sel=%0d n=%0d got=%b want=%b", sel, n, o_done, exp_done);
            end
            total++;
            if (o_busy !== exp_busy) begin
                bad++;
                $display("FAIL busy sel=%0d n=%0d got=%b want=%b", sel, n, o_busy, exp_busy);
            end
            total++;
            if (o_ready !== exp_ready) begin
                bad++;
                $display("FAIL in_ready sel=%0d n=%0d got=%b want=%b", sel, n, o_ready, exp_ready);
            end
            total++;
            if (o_pc !== code) begin
                bad++;
                $display("FAIL par_code sel=%0d n=%0d got=%h want=%h", sel, n, o_pc, code);
            end

            if (n == 1) pc_obs = o_pc;
            if (exp_frame && (((n - 1) % bc) == 0)) seq_obs[3'(6 - k)] = o_bit;

            // Scramble inputs while the frame runs; none of it may be taken.
            if (n < period) begin
                drive_in(sel, keep_valid, 4'($urandom));
`ifdef HAM_ERR_INJ_EN
                set_err(sel, 1'($urandom), 3'($urandom));
`endif
            end
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        a_rst = 1'b1;
        b_rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({a_in_ready, a_tx_bit, a_tx_frame, a_busy, a_done, a_par_code} !== 12'h000) begin
            bad++;
            $display("FAIL reset_a got=%b want=0", {a_in_ready, a_tx_bit, a_tx_frame, a_busy, a_done, a_par_code});
        end
        total++;
        if ({b_in_ready, b_tx_bit, b_tx_frame, b_busy, b_done, b_par_code} !== 12'h000) begin
            bad++;
            $display("FAIL reset_b got=%b want=0", {b_in_ready, b_tx_bit, b_tx_frame, b_busy, b_done, b_par_code});
        end
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        total++;
        if ({a_in_ready, b_in_ready} !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_reset got=%b want=11", {a_in_ready, b_in_ready});
        end
    endtask

    task automatic test_idle_no_valid();
        repeat (8) begin
            @(negedge clk);
            total++;
            if ({a_in_ready, a_busy, a_tx_frame, a_done} !== 4'b1000) begin
                bad++;
                $display("FAIL idle_a got=%b want=1000", {a_in_ready, a_busy, a_tx_frame, a_done});
            end
            total++;
            if ({b_in_ready, b_busy, b_tx_frame, b_done} !== 4'b1000) begin
                bad++;
                $display("FAIL idle_b got=%b want=1000", {b_in_ready, b_busy, b_tx_frame, b_done});
            end
        end
    endtask

    task automatic test_encode_table();
        logic [6:0] want;
        bit         has_const;
        for (int i = 0; i < 16; i++) begin
            run_frame(1, 4'(i), 1'b0);
            has_const = 1'b1;
            case (i)
                0:       want = 7'h00;
                1:       want = 7'h07;
                11:      want = 7'h55;
                15:      want = 7'h7F;
                default: begin want = 7'h00; has_const = 1'b0; end
            endcase
            if (has_const) begin
                total++;
                if (pc_obs !== want) begin
                    bad++;
                    $display("FAIL encode_const d=%0d got=%h want=%h", i, pc_obs, want);
                end
            end
            total++;
            if (syndrome(pc_obs) !== 3'd0) begin
                bad++;
                $display("FAIL encode_syndrome d=%0d got=%0d want=0", i, syndrome(pc_obs));
            end
        end
    endtask

    task automatic test_serial_order();
        run_frame(0, 4'b1011, 1'b0);
        total++;
        if (seq_obs !== 7'b1010101) begin
            bad++;
            $display("FAIL serial_lsb_first got=%b want=1010101", seq_obs);
        end
        run_frame(1, 4'b0001, 1'b0);
        total++;
        if (seq_obs !== 7'b0000111) begin
            bad++;
            $display("FAIL serial_msb_first got=%b want=0000111", seq_obs);
        end
    endtask

    task automatic test_frame_timing();
        run_frame(0, 4'($urandom), 1'b0);
        run_frame(0, 4'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 4'($urandom), 1'b1);
        run_frame(0, 4'($urandom), 1'b1);
        run_frame(0, 4'($urandom), 1'b0);
        run_frame(1, 4'($urandom), 1'b1);
        run_frame(1, 4'($urandom), 1'b1);
        run_frame(1, 4'($urandom), 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        run_frame(0, 4'($urandom), 1'b0);          // ends with dut_a ready
        drive_in(0, 1'b1, 4'($urandom));
        for (int n = 1; n <= 13; n++) begin         // n=13: first cycle of bit 3
            @(negedge clk);
            drive_in(0, 1'b0, 4'($urandom));
        end
        total++;
        if (a_tx_frame !== 1'b1) begin
            bad++;
            $display("FAIL midframe_active got=%b want=1", a_tx_frame);
        end
        a_rst = 1'b1;
        drive_in(0, 1'b1, 4'($urandom));
        @(negedge clk);
        total++;
        if ({a_tx_frame, a_busy, a_in_ready, a_done, a_tx_bit, a_par_code} !== 12'h000) begin
            bad++;
            $display("FAIL midframe_reset got=%b want=0", {a_tx_frame, a_busy, a_in_ready, a_done, a_tx_bit, a_par_code});
        end
        drive_in(0, 1'b0, 4'd0);
        @(negedge clk);
        a_rst = 1'b0;
        #1;
        total++;
        if (a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_midframe_reset got=%b want=1", a_in_ready);
        end
        repeat (40) begin
            @(negedge clk);
            total++;
            if ({a_done, a_tx_frame, a_busy} !== 3'b000) begin
                bad++;
                $display("FAIL abandoned_frame got=%b want=000", {a_done, a_tx_frame, a_busy});
            end
        end
    endtask

    task automatic test_reset_vs_accept();
        a_rst = 1'b1;
        drive_in(0, 1'b1, 4'($urandom));
        #1;
        total++;
        if (a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_during_reset got=%b want=0", a_in_ready);
        end
        @(negedge clk);
        total++;
        if ({a_tx_frame, a_busy, a_par_code} !== 9'h000) begin
            bad++;
            $display("FAIL reset_beats_accept got=%b want=0", {a_tx_frame, a_busy, a_par_code});
        end
        a_rst = 1'b0;
        drive_in(0, 1'b0, 4'd0);
        #1;
        total++;
        if (a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset_vs_accept got=%b want=1", a_in_ready);
        end
    endtask

    task automatic test_random();
        int sel;
        int idle;
        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(0, 1));
            run_frame(sel, 4'($urandom), 1'b0);
            idle = int'($urandom_range(0, 3));
            for (int j = 0; j < idle; j++) begin
                @(negedge clk);
                total++;
                if ({a_in_ready, a_busy, b_in_ready, b_busy} !== 4'b1010) begin
                    bad++;
                    $display("FAIL random_idle got=%b want=1010", {a_in_ready, a_busy, b_in_ready, b_busy});
                end
            end
        end
    endtask

`ifdef HAM_ERR_INJ_EN
    task automatic test_err_inj();
        logic [2:0] s;
        logic [6:0] fixed;
        cur_err_en  = 1'b1;
        cur_err_pos = 3'd3;
        run_frame(0, 4'b1011, 1'b0);
        total++;
        if (pc_obs !== 7'h51) begin
            bad++;
            $display("FAIL errinj_pos3 got=%h want=51", pc_obs);
        end
        s     = syndrome(pc_obs);
        fixed = pc_obs;
        if (s != 3'd0) fixed[s - 3'd1] = ~fixed[s - 3'd1];
        total++;
        if ({s, fixed[6], fixed[5], fixed[4], fixed[2]} !== {3'd3, 4'b1011}) begin
            bad++;
            $display("FAIL errinj_decode got syn=%0d data=%b want syn=3 data=1011",
                     s, {fixed[6], fixed[5], fixed[4], fixed[2]});
        end
        cur_err_pos = 3'd0;
        run_frame(0, 4'b1011, 1'b0);
        total++;
        if (pc_obs !== 7'h55) begin
            bad++;
            $display("FAIL errinj_pos0 got=%h want=55", pc_obs);
        end
        for (int p = 1; p < 8; p++) begin
            cur_err_pos = 3'(p);
            run_frame(1, 4'($urandom), 1'b0);
            total++;
            if (syndrome(pc_obs) !== 3'(p)) begin
                bad++;
                $display("FAIL errinj_syndrome pos=%0d got=%0d want=%0d", p, syndrome(pc_obs), p);
            end
        end
        cur_err_en  = 1'b0;
        cur_err_pos = 3'd0;
        set_err(0, 1'b0, 3'd0);
        set_err(1, 1'b0, 3'd0);
    endtask
`endif

    initial begin
        a_rst      = 1'b1;
        b_rst      = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        a_in_data  = 4'd0;
        b_in_data  = 4'd0;
        pc_obs     = 7'd0;
        seq_obs    = 7'd0;
`ifdef HAM_ERR_INJ_EN
        a_err_en    = 1'b0;
        b_err_en    = 1'b0;
        a_err_pos   = 3'd0;
        b_err_pos   = 3'd0;
        cur_err_en  = 1'b0;
        cur_err_pos = 3'd0;
`endif
        test_reset();
        test_idle_no_valid();
        test_encode_table();
        test_serial_order();
        test_frame_timing();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_vs_accept();
        test_random();
`ifdef HAM_ERR_INJ_EN
        test_err_inj();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
